// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one single-request cache controller among NUM_REQ requesters.
// Optional WAIT-state timeout is enabled by defining CACHE_ARB_TIMEOUT_EN.
module cache_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  localparam int GID_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_type_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        resp_done_o,
  output logic                      resp_err_o,
  output logic [DATA_W-1:0]         resp_rdata_o,
  output logic [GID_W-1:0]          grant_id_o,
  output logic                      cache_req_valid,
  output logic                      cache_req_type,
  output logic [ADDR_W-1:0]         cache_addr,
  output logic [DATA_W-1:0]         cache_wdata,
  input  logic                      done_cache,
  input  logic [DATA_W-1:0]         cache_rdata,
  output logic                      timeout_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                           state;
  logic [GID_W-1:0]                 rr_ptr;
  logic [GID_W-1:0]                 sel;
  logic                             sel_v;
  logic [GID_W-1:0]                 nxt_ptr;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   addr_a;
  logic [NUM_REQ-1:0][DATA_W-1:0]   wdata_a;

  assign addr_a  = req_addr_i;
  assign wdata_a = req_wdata_i;
  assign nxt_ptr = (grant_id_o == GID_W'(NUM_REQ-1)) ? '0 : grant_id_o + 1'b1;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int j;
    sel   = '0;
    sel_v = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!sel_v && req_valid_i[j[GID_W-1:0]]) begin
        sel_v = 1'b1;
        sel   = j[GID_W-1:0];
      end
    end
  end

  // Accept is combinational; reset suppresses it since nothing is latched that cycle.
  always_comb begin
    req_ready_o = '0;
    if (state == S_IDLE && sel_v && !rst)
      req_ready_o = NUM_REQ'(1) << sel;
  end

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 255) ? 16 : 8;
  logic [CNT_W-1:0] wait_cnt;
`else
  assign resp_err_o    = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      rr_ptr          <= '0;
      grant_id_o      <= '0;
      cache_req_valid <= 1'b0;
      cache_req_type  <= 1'b0;
      cache_addr      <= '0;
      cache_wdata     <= '0;
      resp_done_o     <= '0;
      resp_rdata_o    <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
      resp_err_o      <= 1'b0;
      timeout_err_o   <= 1'b0;
      wait_cnt        <= '0;
`endif
    end else begin
      resp_done_o <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
      resp_err_o  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (sel_v) begin
            cache_req_type  <= req_type_i[sel];
            cache_addr      <= addr_a[sel];
            cache_wdata     <= wdata_a[sel];
            grant_id_o      <= sel;
            cache_req_valid <= 1'b1;
            state           <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cache_req_valid <= 1'b0;
          state           <= S_WAIT;
`ifdef CACHE_ARB_TIMEOUT_EN
          wait_cnt        <= '0;
`endif
        end
        S_WAIT: begin
          // cache_* registers are left untouched: the controller re-reads them during refill.
          if (done_cache) begin
            resp_rdata_o <= cache_rdata;
            resp_done_o  <= NUM_REQ'(1) << grant_id_o;
            rr_ptr       <= nxt_ptr;
            state        <= S_IDLE;
          end
`ifdef CACHE_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT-1)) begin
            resp_rdata_o  <= '0;
            resp_done_o   <= NUM_REQ'(1) << grant_id_o;
            resp_err_o    <= 1'b1;
            timeout_err_o <= 1'b1;
            rr_ptr        <= nxt_ptr;
            state         <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Scoreboard bench for cache_req_arbiter: randomized requesters against a queue-based
// round-robin model; a free-running monitor pops expectations as the DUT responds.
module tb_cache_req_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int GW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid_i, req_type_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [N-1:0]    req_ready_o, resp_done_o;
  logic            resp_err_o;
  logic [DW-1:0]   resp_rdata_o;
  logic [GW-1:0]   grant_id_o;
  logic            cache_req_valid, cache_req_type;
  logic [AW-1:0]   cache_addr;
  logic [DW-1:0]   cache_wdata;
  logic            done_cache;
  logic [DW-1:0]   cache_rdata;
  logic            timeout_err_o;

  cache_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_type_i(req_type_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o), .resp_done_o(resp_done_o),
    .resp_err_o(resp_err_o), .resp_rdata_o(resp_rdata_o),
    .grant_id_o(grant_id_o),
    .cache_req_valid(cache_req_valid), .cache_req_type(cache_req_type),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .done_cache(done_cache), .cache_rdata(cache_rdata),
    .timeout_err_o(timeout_err_o)
  );

  always #5 clk = ~clk;

  typedef struct { int g; logic typ; logic [AW-1:0] addr; logic [DW-1:0] wdata; } gexp_t;
  typedef struct { int g; logic [DW-1:0] rdata; } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    n_chk = 0;
  int    n_fail = 0;

  // Reference model state: pending set, per-requester payload, round-robin pointer.
  int            rr_m = 0;
  bit            pend[N];
  logic          m_typ[N];
  logic [AW-1:0] m_addr[N];
  logic [DW-1:0] m_wd[N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid_i[i]            = pend[i];
      req_type_i[i]             = m_typ[i];
      req_addr_i[i*AW +: AW]    = m_addr[i];
      req_wdata_i[i*DW +: DW]   = m_wd[i];
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (pend[(rr_m + k) % N]) return (rr_m + k) % N;
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Called at a falling edge while the arbiter is idle; returns at the falling edge of the
  // cycle in which resp_done_o is expected.
  task automatic do_txn(input logic [N-1:0] add, input int lat, input bit spur,
                        input bit rnd, input logic [DW-1:0] rd);
    int g, gd;
    bit got;
    for (int i = 0; i < N; i++)
      if (add[i] && !pend[i]) begin
        pend[i] = 1'b1;
        if (rnd) begin
          m_addr[i] = $urandom;
          m_wd[i]   = $urandom;
          m_typ[i]  = 1'($urandom_range(0, 1));
        end
      end
    if (!any_pend()) return;
    drive_reqs();
    g = pick();
    gq.push_back('{g, m_typ[g], m_addr[g], m_wd[g]});
    rr_m = (g + 1) % N;
    got = 1'b0;
    gd  = g;
    for (int t = 0; t < 50; t++) begin
      #1;
      if (req_ready_o != '0) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL grant_wait: got no req_ready_o expected requester %0d", g);
      return;
    end
    for (int i = 0; i < N; i++) if (req_ready_o[i]) gd = i;
    @(negedge clk);               // ISSUE
    pend[gd] = 1'b0;
    drive_reqs();
    done_cache  = spur;
    cache_rdata = $urandom;
    repeat (lat) begin
      @(negedge clk);
      done_cache = 1'b0;
    end
    @(negedge clk);
    done_cache  = 1'b1;
    cache_rdata = rd;
    rq.push_back('{g, rd});
    @(negedge clk);
    done_cache = spur;            // arrives in IDLE (or ISSUE of the next grant): ignored
  endtask

  // Monitor: samples 2 time units after the falling edge, away from stimulus changes.
  gexp_t cur;
  rexp_t r;
  bit    cur_v = 1'b0;
  int    since = 0;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        cur_v = 1'b0;
      end else begin
        if (cur_v) since++;
        if (resp_done_o != '0) begin
          if (rq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL resp_unexpected: got resp_done_o %0h expected none", resp_done_o);
          end else begin
            r = rq.pop_front();
            chk("resp_done", 64'(resp_done_o), 64'(1) << r.g);
            chk("resp_rdata", 64'(resp_rdata_o), 64'(r.rdata));
            chk("resp_err", 64'(resp_err_o), 64'(0));
          end
          cur_v = 1'b0;
        end
        chk("cache_req_valid", 64'(cache_req_valid), 64'(cur_v && since == 1));
        if (cur_v && since >= 1) begin
          chk("cache_addr", 64'(cache_addr), 64'(cur.addr));
          chk("cache_wdata", 64'(cache_wdata), 64'(cur.wdata));
          chk("cache_req_type", 64'(cache_req_type), 64'(cur.typ));
          chk("grant_id", 64'(grant_id_o), 64'(cur.g));
        end
        if (req_ready_o != '0) begin
          if (gq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL ready_unexpected: got req_ready_o %0h expected none", req_ready_o);
          end else begin
            cur = gq.pop_front();
            chk("req_ready", 64'(req_ready_o), 64'(1) << cur.g);
            cur_v = 1'b1;
            since = 0;
          end
        end
        chk("timeout_err", 64'(timeout_err_o), 64'(0));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cache_req_valid"}, 64'(cache_req_valid), 64'(0));
    chk({tag, "_cache_addr"}, 64'(cache_addr), 64'(0));
    chk({tag, "_cache_wdata"}, 64'(cache_wdata), 64'(0));
    chk({tag, "_cache_req_type"}, 64'(cache_req_type), 64'(0));
    chk({tag, "_grant_id"}, 64'(grant_id_o), 64'(0));
    chk({tag, "_resp_done"}, 64'(resp_done_o), 64'(0));
    chk({tag, "_resp_rdata"}, 64'(resp_rdata_o), 64'(0));
    chk({tag, "_req_ready"}, 64'(req_ready_o), 64'(0));
    chk({tag, "_timeout_err"}, 64'(timeout_err_o), 64'(0));
  endtask

  task automatic drain();
    for (int k = 0; k < N + 1; k++)
      if (any_pend()) do_txn('0, $urandom_range(1, 6), 1'b0, 1'b0, $urandom);
  endtask

  initial begin
    int g;
    logic [N-1:0] add;
    rst = 1'b1;
    done_cache = 1'b0;
    cache_rdata = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; m_typ[i] = 1'b0; m_addr[i] = '0; m_wd[i] = '0;
    end
    drive_reqs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 chk_all_zero("reset");
    @(negedge clk);

    // Single read from requester 0; done one WAIT cycle in.
    m_addr[0] = 32'h100; m_typ[0] = 1'b0; m_wd[0] = '0;
    do_txn(3'b001, 1, 1'b0, 1'b0, 32'hDEADBEEF);

    // Contention between requesters 0 and 1, re-raising after each acceptance.
    for (int k = 0; k < 4; k++) do_txn(3'b011, $urandom_range(1, 4), 1'b1, 1'b1, $urandom);
    drain();

    // Long write: payload must stay stable across 20 WAIT cycles.
    m_addr[1] = 32'h200; m_wd[1] = 32'h12345678; m_typ[1] = 1'b1;
    do_txn(3'b010, 20, 1'b1, 1'b0, $urandom);

    // Random mix.
    for (int k = 0; k < 40; k++) begin
      add = N'($urandom_range(0, (1 << N) - 1));
      if (!any_pend() && add == '0) add = N'(1) << $urandom_range(0, N - 1);
      do_txn(add, $urandom_range(1, 12), 1'($urandom_range(0, 1)), 1'b1, $urandom);
    end
    drain();

    // Reset in the fifth WAIT cycle of a requester-1 transaction.
    pend[1] = 1'b1; m_addr[1] = $urandom; m_wd[1] = $urandom; m_typ[1] = 1'b1;
    drive_reqs();
    g = pick();
    gq.push_back('{g, m_typ[g], m_addr[g], m_wd[g]});
    #1 chk("pre_reset_ready", 64'(req_ready_o), 64'(1) << g);
    @(negedge clk);
    pend[1] = 1'b0;
    drive_reqs();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_m = 0;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    do_txn(3'b011, 2, 1'b0, 1'b1, $urandom);   // rr restarts at 0
    drain();

    done_cache = 1'b0;
    repeat (5) @(negedge clk);
    chk("grant_queue_empty", 64'(gq.size()), 64'(0));
    chk("resp_queue_empty", 64'(rq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
